// File: rtl/event_capture_pkg.sv
// Shared widths, types and the round-robin index helper for the one-hot event capture block.
package event_capture_pkg;

  localparam int NUM_LINES = 8;
  localparam int IDX_W     = 3;

  typedef logic [NUM_LINES-1:0] line_vec_t;
  typedef logic [IDX_W-1:0]     line_idx_t;

  // Eight lines fill the index width exactly, so the increment wraps 7 -> 0 on its own.
  function automatic line_idx_t rrNext(input line_idx_t idx);
    return idx + line_idx_t'(1);
  endfunction

endpackage

// File: rtl/debounce_line.sv
// One input line: two-flop synchroniser, debounce counter and accepted level, with a
// single-cycle rise strobe in the cycle the accepted level flips from 0 to 1.
module debounce_line
  import event_capture_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o
);

  localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       s1_q;
  logic       s2_q;
  logic       stable_q;
  logic       stable_d;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic       atLast;

  assign atLast = (cnt_q == LAST);

  // The counter only runs while the synchronised level disagrees with the accepted one.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (s2_q != stable_q) begin
      if (atLast) begin
        stable_d = s2_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= raw_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = s2_q & ~stable_q & atLast;

endmodule

// File: rtl/onehot_event_capture_8.sv
// Captures debounced rising edges on eight lines, queues one flag per line and releases
// them one at a time, round-robin, as a strictly one-hot word over valid/ready.
module onehot_event_capture_8
  import event_capture_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LINES-1:0] raw_in,
  output logic [NUM_LINES-1:0] out_onehot,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NUM_LINES-1:0] pending,
  output logic [NUM_LINES-1:0] overrun
);

  line_vec_t rise;
  line_vec_t stableVec;
  line_vec_t pending_q;
  line_vec_t pending_d;
  line_vec_t overrun_q;
  line_vec_t overrun_d;
  line_vec_t outOnehot_q;
  line_vec_t outOnehot_d;
  line_vec_t clearMask;
  logic      outValid_q;
  logic      outValid_d;
  line_idx_t ptr_q;
  line_idx_t ptr_d;
  line_idx_t grantIdx;
  line_idx_t cand;
  logic      load;
  logic      transfer;
  logic      unusedStable;

  for (genvar g = 0; g < NUM_LINES; g++) begin : gLine
    debounce_line #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) uLine (
      .clk     (clk),
      .rst     (rst),
      .raw_i   (raw_in[g]),
      .stable_o(stableVec[g]),
      .rise_o  (rise[g])
    );
  end

  assign unusedStable = ^stableVec;

  // Scan from the farthest offset back to ptr so the nearest pending line wins.
  always_comb begin
    grantIdx = ptr_q;
    cand     = '0;
    for (int k = NUM_LINES - 1; k >= 0; k--) begin
      cand = ptr_q + line_idx_t'(k);
      if (pending_q[cand]) begin
        grantIdx = cand;
      end
    end
  end

  assign transfer = outValid_q & out_ready;
  assign load     = (~outValid_q | out_ready) & (|pending_q);

  // Loads only see last cycle's flags; a same-cycle rise is applied after the clear so the set wins.
  always_comb begin
    clearMask   = '0;
    outOnehot_d = outOnehot_q;
    outValid_d  = outValid_q;
    ptr_d       = ptr_q;
    if (load) begin
      clearMask[grantIdx] = 1'b1;
      outOnehot_d         = line_vec_t'(1) << grantIdx;
      outValid_d          = 1'b1;
      ptr_d               = rrNext(grantIdx);
    end else if (transfer) begin
      outOnehot_d = '0;
      outValid_d  = 1'b0;
    end
    pending_d = (pending_q & ~clearMask) | rise;
    overrun_d = rise & pending_q & ~clearMask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q   <= '0;
      overrun_q   <= '0;
      outOnehot_q <= '0;
      outValid_q  <= 1'b0;
      ptr_q       <= '0;
    end else begin
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      outOnehot_q <= outOnehot_d;
      outValid_q  <= outValid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_onehot = outOnehot_q;
  assign out_valid  = outValid_q;
  assign pending    = pending_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_onehot_event_capture_8.sv
// Bench for onehot_event_capture_8: directed scenarios and a randomized phase, with grants
// scored against a behavioural model of debounce windows, pending flags and round-robin order.
module tb_onehot_event_capture_8;

  localparam int D = 4;

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic [7:0] raw_in    = '0;
  logic       out_ready = 1'b0;
  logic [7:0] out_onehot;
  logic [7:0] pending;
  logic [7:0] overrun;
  logic       out_valid;

  int  checks     = 0;
  int  fails      = 0;
  int  grantsSeen = 0;
  bit  started    = 1'b0;
  logic [7:0] expQ[$];

  logic [7:0] mS1      = '0;
  logic [7:0] mS2      = '0;
  logic [7:0] mStable  = '0;
  logic [7:0] mPend    = '0;
  logic [7:0] mOnehot  = '0;
  logic [7:0] mOverrun = '0;
  logic       mValid   = 1'b0;
  int         mPtr     = 0;
  logic [7:0] mWin[$];

  always #5 clk = ~clk;

  onehot_event_capture_8 #(
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .raw_in    (raw_in),
    .out_onehot(out_onehot),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pending   (pending),
    .overrun   (overrun)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a level is accepted once the last D synchronised samples all disagree
  // with it; accepted rises queue a flag and grants go to the nearest flag at or after ptr.
  always @(posedge clk) begin : model
    logic [7:0] rise;
    logic [7:0] clr;
    logic [7:0] newStable;
    bit         flip;
    bit         transferM;
    bit         loadM;
    int         g;
    if (rst) begin
      started  = 1'b1;
      mS1      = '0;
      mS2      = '0;
      mStable  = '0;
      mPend    = '0;
      mOnehot  = '0;
      mOverrun = '0;
      mValid   = 1'b0;
      mPtr     = 0;
      mWin.delete();
      for (int k = 0; k < D; k++) mWin.push_back(8'h00);
      expQ.delete();
    end else begin
      mWin.push_back(mS2);
      if (mWin.size() > D) void'(mWin.pop_front());
      rise      = '0;
      newStable = mStable;
      for (int i = 0; i < 8; i++) begin
        flip = (mWin.size() == D);
        foreach (mWin[k]) if (mWin[k][i] == mStable[i]) flip = 1'b0;
        if (flip) begin
          newStable[i] = ~mStable[i];
          if (!mStable[i]) rise[i] = 1'b1;
        end
      end
      transferM = mValid && out_ready;
      loadM     = (!mValid || out_ready) && (mPend != 0);
      clr       = '0;
      if (loadM) begin
        g = -1;
        for (int k = 0; k < 8; k++) if (g < 0 && mPend[(mPtr + k) % 8]) g = (mPtr + k) % 8;
        clr[g]  = 1'b1;
        mOnehot = 8'd1 << g;
        mValid  = 1'b1;
        mPtr    = (g + 1) % 8;
        expQ.push_back(mOnehot);
      end else if (transferM) begin
        mValid  = 1'b0;
        mOnehot = '0;
      end
      mOverrun = rise & mPend & ~clr;
      mPend    = (mPend & ~clr) | rise;
      mStable  = newStable;
      mS2      = mS1;
      mS1      = raw_in;
    end
  end

  // Monitor: per-cycle state against the model, and each handshake against the scoreboard.
  always @(negedge clk) begin
    if (started) begin
      checkOutput("out_valid", {31'b0, out_valid}, {31'b0, mValid});
      checkOutput("out_onehot", {24'b0, out_onehot}, {24'b0, mOnehot});
      checkOutput("pending", {24'b0, pending}, {24'b0, mPend});
      checkOutput("overrun", {24'b0, overrun}, {24'b0, mOverrun});
      if (!rst && out_valid && out_ready) begin
        grantsSeen++;
        if (expQ.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL grant: got %0h, expected no grant at %0t", out_onehot, $time);
        end else begin
          checkOutput("grant", {24'b0, out_onehot}, {24'b0, expQ.pop_front()});
        end
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] raw, input logic rdy, input logic rstV,
                               input int cycles);
    raw_in    = raw;
    out_ready = rdy;
    rst       = rstV;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitValid(output int lat);
    lat = -1;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = e;
        break;
      end
    end
  endtask

  task automatic expectGrants(input logic [7:0] raw, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c);
    int lat;
    waitValid(lat);
    checkOutput("rr_first", {24'b0, out_onehot}, {24'b0, a});
    applyStimulus(raw, 1'b1, 1'b0, 1);
    checkOutput("rr_second", {24'b0, out_onehot}, {24'b0, b});
    applyStimulus(raw, 1'b1, 1'b0, 1);
    checkOutput("rr_third", {24'b0, out_onehot}, {24'b0, c});
    applyStimulus(raw, 1'b1, 1'b0, 1);
    checkOutput("rr_drained", {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    int lat;
    int g0;
    logic [7:0] ov;
    logic [7:0] rawR;

    // Reset and single event with latency
    applyStimulus(8'h00, 1'b1, 1'b1, 2);
    checkOutput("reset_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset_onehot", {24'b0, out_onehot}, 32'd0);
    checkOutput("reset_pending", {24'b0, pending}, 32'd0);
    applyStimulus(8'h08, 1'b1, 1'b0, 0);
    waitValid(lat);
    checkOutput("latency", lat, 32'd6);
    checkOutput("single_onehot", {24'b0, out_onehot}, 32'h08);
    applyStimulus(8'h08, 1'b1, 1'b0, 1);
    checkOutput("single_one_cycle", {31'b0, out_valid}, 32'd0);
    applyStimulus(8'h00, 1'b1, 1'b0, 10);

    // Glitch rejection
    g0 = grantsSeen;
    applyStimulus(8'h20, 1'b1, 1'b0, 3);
    applyStimulus(8'h00, 1'b1, 1'b0, 12);
    checkOutput("glitch_pending", {24'b0, pending}, 32'd0);
    checkOutput("glitch_grants", grantsSeen, g0);
    applyStimulus(8'h20, 1'b1, 1'b0, 4);
    applyStimulus(8'h00, 1'b1, 1'b0, 0);
    waitValid(lat);
    checkOutput("pulse4_onehot", {24'b0, out_onehot}, 32'h20);
    applyStimulus(8'h00, 1'b1, 1'b0, 12);
    checkOutput("pulse4_grants", grantsSeen, g0 + 1);

    // Round robin, two bursts from ptr 0
    applyStimulus(8'h00, 1'b1, 1'b1, 1);
    applyStimulus(8'h85, 1'b1, 1'b0, 0);
    expectGrants(8'h85, 8'h01, 8'h04, 8'h80);
    applyStimulus(8'h00, 1'b1, 1'b0, 10);
    applyStimulus(8'h85, 1'b1, 1'b0, 0);
    expectGrants(8'h85, 8'h01, 8'h04, 8'h80);
    applyStimulus(8'h00, 1'b1, 1'b0, 10);

    // Backpressure
    applyStimulus(8'h00, 1'b0, 1'b1, 1);
    applyStimulus(8'h02, 1'b0, 1'b0, 0);
    waitValid(lat);
    checkOutput("bp_first", {24'b0, out_onehot}, 32'h02);
    applyStimulus(8'h50, 1'b0, 1'b0, 10);
    checkOutput("bp_hold", {24'b0, out_onehot}, 32'h02);
    checkOutput("bp_pending", {24'b0, pending}, 32'h50);
    applyStimulus(8'h50, 1'b1, 1'b0, 1);
    checkOutput("bp_second", {24'b0, out_onehot}, 32'h10);
    applyStimulus(8'h50, 1'b1, 1'b0, 1);
    checkOutput("bp_third", {24'b0, out_onehot}, 32'h40);
    applyStimulus(8'h00, 1'b1, 1'b0, 10);

    // Overrun
    applyStimulus(8'h01, 1'b0, 1'b0, 0);
    waitValid(lat);
    checkOutput("ov_occupy", {24'b0, out_onehot}, 32'h01);
    applyStimulus(8'h05, 1'b0, 1'b0, 8);
    checkOutput("ov_pending", {24'b0, pending}, 32'h04);
    applyStimulus(8'h01, 1'b0, 1'b0, 8);
    ov = '0;
    for (int e = 0; e < 20; e++) begin
      applyStimulus(8'h05, 1'b0, 1'b0, 1);
      if (overrun != 8'h00) begin
        ov = overrun;
        break;
      end
    end
    checkOutput("ov_pulse", {24'b0, ov}, 32'h04);
    applyStimulus(8'h05, 1'b0, 1'b0, 1);
    checkOutput("ov_width", {24'b0, overrun}, 32'h00);
    applyStimulus(8'h05, 1'b1, 1'b0, 1);
    checkOutput("ov_deliver", {24'b0, out_onehot}, 32'h04);
    applyStimulus(8'h05, 1'b1, 1'b0, 1);
    checkOutput("ov_single", {31'b0, out_valid}, 32'd0);
    applyStimulus(8'h00, 1'b1, 1'b0, 10);

    // Mid-operation reset
    applyStimulus(8'h00, 1'b0, 1'b1, 1);
    applyStimulus(8'h01, 1'b0, 1'b0, 0);
    waitValid(lat);
    applyStimulus(8'h00, 1'b0, 1'b0, 8);
    applyStimulus(8'hFF, 1'b0, 1'b0, 8);
    checkOutput("mr_pending_full", {24'b0, pending}, 32'hFF);
    checkOutput("mr_valid_before", {31'b0, out_valid}, 32'd1);
    applyStimulus(8'h00, 1'b0, 1'b1, 1);
    checkOutput("mr_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("mr_onehot", {24'b0, out_onehot}, 32'd0);
    checkOutput("mr_pending", {24'b0, pending}, 32'd0);
    g0 = grantsSeen;
    applyStimulus(8'h00, 1'b1, 1'b0, 15);
    checkOutput("mr_no_stale", grantsSeen, g0);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      rawR = raw_in;
      for (int i = 0; i < 8; i++) if ($urandom_range(0, 9) == 0) rawR[i] = ~rawR[i];
      applyStimulus(rawR, ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) == 0), 1);
    end
    applyStimulus(8'h00, 1'b1, 1'b0, 40);
    checkOutput("drain_queue_empty", expQ.size(), 32'd0);
    checkOutput("drain_valid", {31'b0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/onehot_event_capture_8.md
# onehot_event_capture_8

Captures rising-edge events on 8 asynchronous input lines and presents them one at a time as a strictly one-hot 8-bit word. Each line is synchronised and debounced, and events are queued per line. A round-robin arbiter then releases them through a valid/ready handshake. It sits directly upstream of the 8-to-3 encoder and guarantees the encoder only ever sees all-zero or exactly one-hot input.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronised cycles a new level must persist before it is accepted. Legal range 1..255.
- `clk`  in  1: single clock. All logic is rising-edge.
- `rst`  in  1: synchronous, active-high reset.
- `raw_in`  in  8: asynchronous event lines, bit i = line i.
- `out_onehot`  out  8: granted event. Exactly one bit set when `out_valid`=1, all zero otherwise.
- `out_valid`  out  1: `out_onehot` holds an event.
- `out_ready`  in  1: downstream accepts. Transfer occurs on `out_valid && out_ready`.
- `pending`  out  8: per-line queued-event flags (status only).
- `overrun`  out  8: one-cycle pulse when line i produces an event while `pending[i]` is already set. The new event is merged, not counted.

## Operation
- Per line: 2-flop synchroniser (`s1`, `s2`), a `stable` flop, and an 8-bit counter `cnt`.
- Debounce, evaluated each edge:
  - If `s2 == stable`, then `cnt <= 0`.
  - Otherwise, if `cnt == DEBOUNCE_CYCLES-1`, then `stable <= s2` and `cnt <= 0`.
  - Otherwise `cnt <= cnt+1`.
- Any `s2` excursion shorter than `DEBOUNCE_CYCLES` cycles is ignored.
- Rise event for line i: `s2 && !stable && cnt == DEBOUNCE_CYCLES-1`. It fires in the same cycle `stable` flips 0→1. Falling edges generate no event.
- A rise event sets `pending[i]`. If `pending[i]` was already 1 and is not being cleared this cycle, `overrun[i]` pulses.
- Output register load:
  - Condition: `out_valid == 0`, or a transfer is occurring, and at least one pending bit is not being set this cycle only.
  - Selection: the first pending bit found searching upward from `ptr`, wrapping 7→0.
  - Action: `out_onehot <= 1<<i`, `out_valid <= 1`, clear `pending[i]`, `ptr <= (i+1) mod 8`.
- Transfer with nothing pending: `out_valid <= 0`, `out_onehot <= 0`.
- Simultaneous load-clear and new rise event on the same line: the set wins. `pending[i]` stays 1 and `overrun[i]` does not pulse.
- While `out_valid=1 && out_ready=0`, `out_onehot` is held unchanged. Events keep accumulating in `pending`.

## Timing
- Reset values: `s1`, `s2`, `stable`, `cnt`, `pending`, `out_onehot`, `out_valid`, `overrun` all 0; `ptr` = 0.
- Latency: let edge 0 be the first edge sampling a new high `raw_in[i]`, with the line idle and the output empty.
  - `stable` and `pending[i]` become 1 after edge `DEBOUNCE_CYCLES+1`.
  - `out_valid` becomes 1 after edge `DEBOUNCE_CYCLES+2` (6 edges for the default).
- Throughput: one event per cycle with `out_ready` held high (back-to-back load on transfer).
- Reset mid-operation: all queued and in-flight events are discarded. A line held high across reset release produces one event after the full latency.
- Overrun pulse width is exactly one cycle.

## Structure
- Package `event_capture_pkg`: `NUM_LINES = 8`, `IDX_W = 3`, typedef `line_vec_t` (8-bit), and a round-robin next-index function.
- Sub-module `debounce_line`, instantiated 8 times. It contains the synchroniser, `stable`, and `cnt`, and outputs `stable` and a one-cycle `rise`.
- The top level holds `pending`, `ptr`, the arbiter, and the output register.

## Test plan
- **Reset and single event:** Hold `rst` 2 cycles, then raise `raw_in[3]` with `out_ready=1`.
  - Outputs are 0 during reset.
  - `out_onehot = 8'h08` and `out_valid = 1` after edge 6, for one cycle.
- **Glitch rejection:** Pulse `raw_in[5]` high for 3 cycles with `DEBOUNCE_CYCLES=4` -> no event and `pending` stays 0. A 4-cycle pulse -> exactly one event, `8'h20`.
- **Round robin:** Raise lines 0, 2 and 7 in the same cycle with `out_ready=1`, `ptr=0` -> grants `8'h01`, `8'h04`, `8'h80` on consecutive cycles. A second burst with `ptr=0` repeats that order.
- **Backpressure:** Hold `out_ready=0` after the line 1 event is presented -> `out_onehot = 8'h02` holds. Events on lines 4 and 6 set `pending = 8'h50`. Release `out_ready` -> grants `8'h10`, then `8'h40`.
- **Overrun:** Hold `out_ready=0` and give line 2 two debounced rises while `pending[2]=1` -> `overrun = 8'h04` for one cycle, and only one line 2 event is later delivered.
- **Mid-operation reset:** Assert `rst` while `pending = 8'hFF` and `out_valid = 1` -> next cycle all outputs are 0 and no stale grants follow.
